// File: rtl/spi_ram_pkg.sv
// Shared command codes, FSM state encoding and a width helper for the SPI RAM slave.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_DATA_DUMMY,
        RD_DATA_TX,
        DONE
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM: one address, write port plus registered read, no reset.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_slave.sv
// SPI slave with integrated RAM; one serial bit per clk edge, 2-bit command then payload.
// Define SPI_RAM_BURST_EN to stream consecutive data words with address auto-increment.
module spi_ram_slave
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy
);

`ifdef SPI_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int SW = max2(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(1);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [SW-2:0]         rx_sh;      // previously sampled bits; current MOSI completes the word
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, mem_addr, a_word;
    logic [1:0]            cmd;
    logic                  last, counting, mem_we, mem_re;

    assign cmd      = {rx_sh[0], MOSI};
    assign a_word   = {rx_sh[ADDR_WIDTH-2:0], MOSI};
    assign counting = (state != IDLE) && (state != DONE);

    always_comb begin
        last = 1'b0;
        case (state)
            CMD:                               last = (cnt == C_LAST);
            WR_ADDR, RD_ADDR:                  last = (cnt == A_LAST);
            WR_DATA, RD_DATA_DUMMY, RD_DATA_TX: last = (cnt == D_LAST);
            default:                           last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (SS_n)
            state_nxt = IDLE;
        else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD:
                    if (last) begin
                        case (cmd)
                            CMD_WR_ADDR: state_nxt = WR_ADDR;
                            CMD_WR_DATA: state_nxt = WR_DATA;
                            CMD_RD_ADDR: state_nxt = RD_ADDR;
                            default:     state_nxt = RD_DATA_DUMMY;
                        endcase
                    end
                WR_ADDR, RD_ADDR: if (last) state_nxt = DONE;
                WR_DATA:          if (last && !BURST) state_nxt = DONE;
                RD_DATA_DUMMY:    if (last) state_nxt = RD_DATA_TX;
                RD_DATA_TX:       if (last && !BURST) state_nxt = DONE;
                default:          state_nxt = state;
            endcase
        end
    end

    // In burst reads the next word is fetched from rd_addr+1 during the current LSB so it is ready with no gap.
    always_comb begin
        busy     = (state != IDLE);
        wdata    = {rx_sh[DATA_WIDTH-2:0], MOSI};
        mem_we   = !SS_n && last && (state == WR_DATA);
        mem_re   = !SS_n && last && ((state == RD_DATA_DUMMY) || (BURST && state == RD_DATA_TX));
        mem_addr = rd_addr;
        if (mem_we)
            mem_addr = wr_addr;
        else if (state == RD_DATA_TX)
            mem_addr = rd_addr + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            MISO    <= 1'b0;
        end else begin
            if (counting && !SS_n)
                rx_sh <= {rx_sh[SW-3:0], MOSI};
            cnt <= (counting && !SS_n && !last && state_nxt == state) ? cnt + CW'(1) : '0;

            if (!SS_n && last) begin
                if (state == WR_ADDR)
                    wr_addr <= a_word;
                if (state == RD_ADDR)
                    rd_addr <= a_word;
                if (BURST && state == WR_DATA)
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                if (BURST && state == RD_DATA_TX)
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end

            if (!SS_n && state == RD_DATA_TX) begin
                if (cnt == '0)
                    {MISO, tx_sh} <= {rdata, 1'b0};
                else
                    {MISO, tx_sh} <= {tx_sh, 1'b0};
            end else
                MISO <= 1'b0;
        end
    end

    spi_ram_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(wdata),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_spi_ram_slave.sv
// Directed bench for spi_ram_slave: table of whole frames plus abort and reset sequences.
module tb_spi_ram_slave;

`ifdef SPI_RAM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, SS_n, MOSI;
    logic MISO, busy;
    int   applied = 0;
    int   miscompares = 0;

    spi_ram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .MISO(MISO),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  cmd;
        logic [63:0] data;
        int          nbits;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input string n, input logic [1:0] c, input logic [63:0] d,
                                input int nb, input logic [63:0] e);
        vec_t v;
        v.name = n; v.cmd = c; v.data = d; v.nbits = nb; v.exp = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic bit_edge(input logic ss, input logic m);
        SS_n = ss;
        MOSI = m;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic [1:0] c, output logic b0);
        bit_edge(1'b0, 1'b0);
        b0 = busy;
        bit_edge(1'b0, c[1]);
        bit_edge(1'b0, c[0]);
    endtask

    task automatic payload(input logic [63:0] d, input int nb, output logic [63:0] cap);
        cap = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            bit_edge(1'b0, d[i]);
            cap = {cap[62:0], MISO};
        end
    endtask

    task automatic run_frame(input string nm, input logic [1:0] c, input logic [63:0] d,
                             input int nb, input logic [63:0] exp);
        logic        b0;
        logic [63:0] cap;
        frame_start(c, b0);
        check({nm, " busy_rise"}, 64'(b0), 64'd1);
        payload(d, nb, cap);
        check({nm, " miso"}, cap, exp);
        bit_edge(1'b1, 1'b0);
        check({nm, " busy_fall"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic        b0;
        logic [63:0] cap;

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset miso", 64'(MISO), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        rst = 1'b0;
        bit_edge(1'b1, 1'b0);

        tbl[0]  = mk("t1 wa27",   2'b00, 64'h27, 8, 64'h0);
        tbl[1]  = mk("t1 wd55",   2'b01, 64'h55, 8, 64'h0);
        tbl[2]  = mk("t1 ra27",   2'b10, 64'h27, 8, 64'h0);
        tbl[3]  = mk("t1 rd",     2'b11, 64'h0, 16, 64'h55);
        tbl[4]  = mk("t2 wa03",   2'b00, 64'h03, 8, 64'h0);
        tbl[5]  = mk("t2 wdFE",   2'b01, 64'hFE, 8, 64'h0);
        tbl[6]  = mk("t2 ra03",   2'b10, 64'h03, 8, 64'h0);
        tbl[7]  = mk("t2 rd",     2'b11, 64'h0, 16, 64'hFE);
        tbl[8]  = mk("pre waFF",  2'b00, 64'hFF, 8, 64'h0);
        tbl[9]  = mk("pre wd5A",  2'b01, 64'h5A, 8, 64'h0);
        tbl[10] = mk("pre wa00",  2'b00, 64'h00, 8, 64'h0);
        tbl[11] = mk("pre wdA5",  2'b01, 64'hA5, 8, 64'h0);
        tbl[12] = mk("t3 waFE",   2'b00, 64'hFE, 8, 64'h0);
        tbl[13] = mk("t3 burst",  2'b01, 64'h112233, 24, 64'h0);
        tbl[14] = mk("t3 raFF",   2'b10, 64'hFF, 8, 64'h0);
        tbl[15] = mk("t3 rdFF",   2'b11, 64'h0, 16, BURST ? 64'h22 : 64'h5A);
        tbl[16] = mk("t3 ra00",   2'b10, 64'h00, 8, 64'h0);
        tbl[17] = mk("t3 rd00",   2'b11, 64'h0, 16, BURST ? 64'h33 : 64'hA5);
        tbl[18] = mk("t4 raFE",   2'b10, 64'hFE, 8, 64'h0);
        tbl[19] = mk("t4 rd3w",   2'b11, 64'h0, 32, BURST ? 64'h112233 : 64'h110000);
        tbl[20] = mk("t5 wa10",   2'b00, 64'h10, 8, 64'h0);
        tbl[21] = mk("t5 wdAA",   2'b01, 64'hAA, 8, 64'h0);

        for (int i = 0; i < 22; i++)
            run_frame(tbl[i].name, tbl[i].cmd, tbl[i].data, tbl[i].nbits, tbl[i].exp);

        // abort after 4 data bits
        frame_start(2'b01, b0);
        payload(64'h5, 4, cap);
        check("abort4 busy_mid", 64'(busy), 64'd1);
        bit_edge(1'b1, 1'b0);
        check("abort4 idle", 64'(busy), 64'd0);
        run_frame("abort4 ra10", 2'b10, 64'h10, 8, 64'h0);
        run_frame("abort4 rd10", 2'b11, 64'h0, 16, 64'hAA);

        // SS_n rises on the same edge as the last data bit
        frame_start(2'b01, b0);
        payload(64'h2A, 7, cap);
        bit_edge(1'b1, 1'b1);
        check("abortlast idle", 64'(busy), 64'd0);
        run_frame("abortlast ra10", 2'b10, 64'h10, 8, 64'h0);
        run_frame("abortlast rd10", 2'b11, 64'h0, 16, 64'hAA);

        // aborted address load keeps the previous wr_addr
        run_frame("aaddr wa10", 2'b00, 64'h10, 8, 64'h0);
        frame_start(2'b00, b0);
        payload(64'h10, 7, cap);
        bit_edge(1'b1, 1'b0);
        run_frame("aaddr wd77", 2'b01, 64'h77, 8, 64'h0);
        run_frame("aaddr ra10", 2'b10, 64'h10, 8, 64'h0);
        run_frame("aaddr rd10", 2'b11, 64'h0, 16, 64'h77);

        // reset in the middle of read TX
        run_frame("rst ra03", 2'b10, 64'h03, 8, 64'h0);
        frame_start(2'b11, b0);
        payload(64'h0, 11, cap);
        check("rst pre miso", 64'(MISO), 64'd1);
        check("rst pre busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst miso", 64'(MISO), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        bit_edge(1'b1, 1'b0);
        rst = 1'b0;
        bit_edge(1'b1, 1'b0);
        run_frame("rst rd_addr0", 2'b11, 64'h0, 16, BURST ? 64'h33 : 64'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
